rr_mux_arb: RTL

RR_MUX_ARB -- requirements
Module: rr_mux_arb

---
 rtl/mux_pkg.sv | 12 +
 rtl/rr_pick.sv | 38 +++
 rtl/rr_mux_arb.sv | 108 ++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin output-register multiplexer.
package mux_pkg;

    localparam int CH_MIN = 2;
    localparam int CH_MAX = 16;

    // A single channel index still needs one bit, so the index width never drops below 1.
    function automatic int cw_of(input int ch);
        return (ch <= 2) ? 1 : $clog2(ch);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational grant picker: the first valid channel at or above ptr, wrapping modulo CH.
module rr_pick import mux_pkg::*; #(
    parameter int CH = 4,
    parameter int CW = cw_of(CH)
) (
    input  logic [CH-1:0] req_valid,
    input  logic [CW-1:0] ptr,
    output logic [CH-1:0] grant,
    output logic [CW-1:0] idx
);

    logic [CH-1:0]   rot_s;
    logic [CH-1:0]   hit_s;
    logic [2*CH-1:0] gdbl_s;
    logic            found_s;
    int              off_s;

    // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate the hit back.
    always_comb begin
        rot_s   = CH'({req_valid, req_valid} >> ptr);
        hit_s   = '0;
        found_s = 1'b0;
        off_s   = 0;
        for (int k = 0; k < CH; k++) begin
            if (!found_s && rot_s[k]) begin
                found_s  = 1'b1;
                hit_s[k] = 1'b1;
                off_s    = k;
            end else begin
                hit_s[k] = 1'b0;
            end
        end
        gdbl_s = {{CH{1'b0}}, hit_s} << ptr;
        grant  = gdbl_s[CH-1:0] | gdbl_s[2*CH-1:CH];
        idx    = CW'((int'(ptr) + off_s) % CH);
    end

endmodule

// File: rtl/rr_mux_arb.sv
// Arbitrated N:1 mux into a single output register with valid/ready handshakes.
// Define RR_MUX_ARB_ROUND_ROBIN_EN for rotating priority; otherwise lowest index wins.
module rr_mux_arb import mux_pkg::*; #(
    parameter  int n  = 32,
    parameter  int CH = 4,
    localparam int CW = cw_of(CH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [CH-1:0]   req_valid,
    output logic [CH-1:0]   req_ready,
    input  logic [CH*n-1:0] req_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [n-1:0]    out_data,
    output logic [CW-1:0]   out_chan
);

    logic          out_valid_q, out_valid_d;
    logic [n-1:0]  out_data_q,  out_data_d;
    logic [CW-1:0] out_chan_q,  out_chan_d;
    logic [CW-1:0] ptr_s;
    logic [CW-1:0] pick_idx_s;
    logic [CH-1:0] grant_s;
    logic          can_load_s;
    logic          in_xfer_s;

    rr_pick #(.CH(CH), .CW(CW)) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr_s),
        .grant     (grant_s),
        .idx       (pick_idx_s)
    );

    // Accept a new word only when the register is empty or draining this cycle.
    always_comb begin
        can_load_s = ~out_valid_q | out_ready;
        if (reset) begin
            req_ready = '0;
        end else if (can_load_s) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
        in_xfer_s = |(req_valid & req_ready);
    end

    // An input transfer overrides the drain so back-to-back words leave no bubble.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        if (in_xfer_s) begin
            out_valid_d = 1'b1;
            out_data_d  = req_data[int'(pick_idx_s) * n +: n];
            out_chan_d  = pick_idx_s;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
        end
    end

`ifdef RR_MUX_ARB_ROUND_ROBIN_EN
    logic [CW-1:0] ptr_q, ptr_d;

    // Priority moves just past the channel that was served.
    always_comb begin
        ptr_d = ptr_q;
        if (in_xfer_s) begin
            ptr_d = (pick_idx_s == CW'(CH - 1)) ? '0 : pick_idx_s + CW'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_s = ptr_q;
`else
    assign ptr_s = '0;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule
